// File: rtl/hdmi_packet_pkg.sv
// Shared constants for HDMI data-island packet serialization: BCH polynomial,
// packet geometry and the bit layout of the 9-bit packet_data word.
package hdmi_packet_pkg;

    localparam logic [7:0] BCH_POLY      = 8'h83;
    localparam int         PACKET_PIXELS = 32;
    localparam int         HEADER_BITS   = 24;
    localparam int         SUB_BITS      = 56;
    localparam int         NUM_SUBS      = 4;

    // Pixels that carry payload before the parity bits take over
    localparam int HEADER_DATA_PIXELS = HEADER_BITS;
    localparam int SUB_DATA_PIXELS    = SUB_BITS / 2;

    // packet_data = {ch2[3:0], ch1[3:0], ch0_bit2}
    localparam int PD_CH0_BIT = 0;
    localparam int PD_CH1_LSB = 1;
    localparam int PD_CH2_LSB = 5;
    localparam int PD_WIDTH   = 9;

endpackage

// File: rtl/bch_ecc_step.sv
// Combinational BCH parity update for 1 or 2 data bits per call; bit 0 of
// data is folded in first.
module bch_ecc_step
    import hdmi_packet_pkg::*;
#(
    parameter int BITS_PER_STEP = 1
)
(
    input  logic [7:0]               ecc,
    input  logic [BITS_PER_STEP-1:0] data,
    output logic [7:0]               ecc_next
);

    always_comb begin
        ecc_next = ecc;
        for (int b = 0; b < BITS_PER_STEP; b++) begin
            ecc_next = (ecc_next >> 1) ^ ((data[b] ^ ecc_next[0]) ? BCH_POLY : 8'h00);
        end
    end

endmodule

// File: rtl/packet_ecc_serializer.sv
// Serializes header + four subpackets into 32 data-island pixels, appending
// serially computed BCH parity; owns the packet pixel counter and packet_enable.
module packet_ecc_serializer
    import hdmi_packet_pkg::*;
(
    input  logic                               clk_pixel,
    input  logic                               reset_n,
    input  logic                               data_island_period,
    input  logic [HEADER_BITS-1:0]             header,
    input  logic [NUM_SUBS-1:0][SUB_BITS-1:0]  sub,
    output logic                               packet_enable,
    output logic [4:0]                         packet_pixel_counter,
    output logic [PD_WIDTH-1:0]                packet_data
);

    logic [4:0]                         cnt;
    logic [HEADER_BITS-1:0]             hdr_shadow;
    logic [NUM_SUBS-1:0][SUB_BITS-1:0]  sub_shadow;
    logic [7:0]                         ecc_h;
    logic [NUM_SUBS-1:0][7:0]           ecc_s;

    logic                               first;
    logic [31:0]                        hdr_ext;
    logic                               hdr_bit;
    logic [7:0]                         ecc_h_cur;
    logic [7:0]                         ecc_h_step;
    logic [NUM_SUBS-1:0][63:0]          sub_ext;
    logic [NUM_SUBS-1:0][1:0]           sub_bits;
    logic [NUM_SUBS-1:0][7:0]           ecc_s_cur;
    logic [NUM_SUBS-1:0][7:0]           ecc_s_step;
    logic [PD_WIDTH-1:0]                pix;

    assign first                = (cnt == 5'd0);
    assign packet_enable        = data_island_period && (cnt == 5'd31);
    assign packet_pixel_counter = cnt;

    // Pixel 0 consumes the live inputs and a zero parity seed so a packet
    // chosen on the previous edge is serialized without an extra cycle.
    assign hdr_ext   = {8'd0, (first ? header : hdr_shadow)};
    assign hdr_bit   = hdr_ext[cnt];
    assign ecc_h_cur = first ? 8'h00 : ecc_h;

    bch_ecc_step #(.BITS_PER_STEP(1)) u_hdr_ecc (
        .ecc      (ecc_h_cur),
        .data     (hdr_bit),
        .ecc_next (ecc_h_step)
    );

    for (genvar i = 0; i < NUM_SUBS; i++) begin : g_sub
        assign sub_ext[i]   = {8'd0, (first ? sub[i] : sub_shadow[i])};
        assign sub_bits[i]  = sub_ext[i][{cnt, 1'b0} +: 2];
        assign ecc_s_cur[i] = first ? 8'h00 : ecc_s[i];

        bch_ecc_step #(.BITS_PER_STEP(2)) u_sub_ecc (
            .ecc      (ecc_s_cur[i]),
            .data     (sub_bits[i]),
            .ecc_next (ecc_s_step[i])
        );
    end

    always_comb begin
        pix = '0;
        pix[PD_CH0_BIT] = (cnt < 5'(HEADER_DATA_PIXELS)) ? hdr_bit : ecc_h[cnt[2:0]];
        for (int i = 0; i < NUM_SUBS; i++) begin
            if (cnt < 5'(SUB_DATA_PIXELS)) begin
                pix[PD_CH1_LSB + i] = sub_bits[i][0];
                pix[PD_CH2_LSB + i] = sub_bits[i][1];
            end else begin
                pix[PD_CH1_LSB + i] = ecc_s[i][{cnt[1:0], 1'b0}];
                pix[PD_CH2_LSB + i] = ecc_s[i][{cnt[1:0], 1'b1}];
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            hdr_shadow  <= '0;
            sub_shadow  <= '0;
            ecc_h       <= '0;
            ecc_s       <= '0;
            packet_data <= '0;
        end else if (!data_island_period) begin
            // Leaving the island aborts any partial packet
            cnt         <= '0;
            ecc_h       <= '0;
            ecc_s       <= '0;
            packet_data <= '0;
        end else begin
            cnt         <= cnt + 5'd1;
            packet_data <= pix;
            if (first) begin
                hdr_shadow <= header;
                sub_shadow <= sub;
            end
            if (cnt < 5'(HEADER_DATA_PIXELS)) ecc_h <= ecc_h_step;
            for (int i = 0; i < NUM_SUBS; i++) begin
                if (cnt < 5'(SUB_DATA_PIXELS)) ecc_s[i] <= ecc_s_step[i];
            end
        end
    end

endmodule

// File: doc/packet_ecc_serializer.md
# packet_ecc_serializer

Downstream stage of the HDMI packet picker. It takes the currently selected 24-bit packet header and four 56-bit subpackets and computes the BCH error-correction parity serially. It emits each packet as 32 pixels of 9-bit data-island payload for the TERC4 encoders. It also owns the packet pixel counter and generates the `packet_enable` strobe that tells the picker to choose the next packet.

## Interface
Parameters:
- none; all widths are fixed by the HDMI packet format.

Ports:
- `clk_pixel` in 1: pixel clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `data_island_period` in 1: high during data-island payload pixels.
- `header` in 24: packet header HB2..HB0, LSB = HB0 bit 0.
- `sub` in 4×56: subpackets 0..3, LSB first.
- `packet_enable` out 1: high for the single cycle with `data_island_period` high and counter == 31.
- `packet_pixel_counter` out 5: current pixel index within the packet.
- `packet_data` out 9: {ch2[3:0], ch1[3:0], ch0_bit2}, registered.

## Operation
- Counter:
  - Resets to 0.
  - While `data_island_period` is high, it increments every clock and wraps 31→0.
  - When `data_island_period` is low, it is forced to 0.
- Input capture at counter == 0 with the island active:
  - `header` and `sub` are used directly that cycle and latched into shadow registers.
  - Pixels 1..31 use the shadow copy, so input changes mid-packet are ignored.
- BCH serial rule, applied per data bit d:
  - fb = d ^ ecc[0]
  - ecc ← (ecc >> 1) ^ (fb ? 8'h83 : 0)
- Header block (32 bits), channel 0 bit 2:
  - Pixel n in 0..23 emits header[n] and updates ecc_h with it.
  - Pixel n in 24..31 emits ecc_h[n−24]; ecc_h is frozen.
- Subpacket block i (64 bits), 2 bits per pixel:
  - Pixel n in 0..27: ch1[i] = sub[i][2n], ch2[i] = sub[i][2n+1]. ecc_s[i] is updated twice in the same cycle, bit 2n first, then bit 2n+1.
  - Pixel n in 28..31: ch1[i] = ecc_s[i][2(n−28)], ch2[i] = ecc_s[i][2(n−28)+1].
- All five ECC registers clear to 0 when counter == 0, so a fresh packet starts from zero parity.
- Outside the island, `packet_data` is 0.

## Timing
- Reset values: counter 0, `packet_enable` 0, `packet_data` 9'd0, all ECC and shadow registers 0.
- `packet_data` latency: the value for pixel n appears one clock after the counter shows n.
- `packet_enable` is combinational from the counter and `data_island_period`, with no latency.
  - The picker registers its choice on that edge, so the new `header`/`sub` must be valid in the following cycle (counter == 0).
- `data_island_period` falling mid-packet:
  - The packet is aborted: counter returns to 0 and ECC is discarded.
  - The next island restarts at pixel 0.
  - No `packet_enable` pulse is emitted for the aborted packet.
- `reset_n` asserted mid-packet: all state clears immediately; output is 0 on the next edge after release.
- Back-to-back packets: counter 31→0 with no gap; the ECC clear and the new capture happen in the same cycle.

## Structure
- Shared package `hdmi_packet_pkg` holds:
  - `BCH_POLY = 8'h83`
  - `PACKET_PIXELS = 32`
  - `HEADER_BITS = 24`, `SUB_BITS = 56`
  - the `packet_data` field offsets
- One sub-module, `bch_ecc_step`:
  - Parameter `BITS_PER_STEP` (1 or 2).
  - Combinational next-ECC from the current ECC and the data bits.
  - Instantiated once for the header and four times for the subpackets.

## Test plan
- All-zero header/sub, 2 packets back to back → `packet_data` all 0 for 64 pixels. `packet_enable` pulses exactly at counts 31 and 63.
- `header = 24'h000001`, subs 0 → ch0_bit2 = 1 at pixel 0, 0 at pixels 1..23. Pixels 24..31 emit 0,1,0,1,0,0,1,0 (ecc_h = 8'h4A).
- Random header/subs (1000 packets) versus a bit-serial software BCH model → every emitted pixel bit matches.
- Change `header`/`sub` at pixel 10 → output of the current packet unchanged. The new value appears only at the next pixel 0.
- Drop `data_island_period` at pixel 17, re-raise it after 5 cycles → counter restarts at 0, first output matches pixel 0 of the new packet, no `packet_enable` for the aborted packet.
- Assert `reset_n` low at pixel 20 for 1 cycle → all outputs 0. A packet started afterwards is bit-exact against the model.
